// File: rtl/input_vc_buffer_if.sv
// rtl/input_vc_buffer_if.sv - Port bundle for the per-input VC buffer
// Flit ingress, allocator request/grant, crossbar egress and credit signals.
interface input_vc_buffer_if #(
  parameter int vc_Num = 4,
  parameter int FLIT_W = 32,
  parameter int PORT_W = 3
);
  localparam int VC_W = (vc_Num > 1) ? $clog2(vc_Num) : 1;

  logic                     flit_valid_i;
  logic [VC_W-1:0]          flit_vc_i;
  logic                     flit_head_i;
  logic                     flit_tail_i;
  logic [FLIT_W-1:0]        flit_data_i;
  logic [PORT_W-1:0]        route_i;
  logic [vc_Num-1:0]        request_o;
  logic [vc_Num*PORT_W-1:0] out_port_o;
  logic [vc_Num-1:0]        grant_i;
  logic                     flit_valid_o;
  logic [VC_W-1:0]          flit_vc_o;
  logic                     flit_head_o;
  logic                     flit_tail_o;
  logic [FLIT_W-1:0]        flit_data_o;
  logic [PORT_W-1:0]        flit_port_o;
  logic                     credit_o;
  logic [VC_W-1:0]          credit_vc_o;
  logic                     credit_valid_i;
  logic [VC_W-1:0]          credit_vc_i;
  logic                     err_o;

  modport slave (
    input  flit_valid_i, flit_vc_i, flit_head_i, flit_tail_i, flit_data_i, route_i,
    input  grant_i, credit_valid_i, credit_vc_i,
    output request_o, out_port_o, flit_valid_o, flit_vc_o, flit_head_o, flit_tail_o,
    output flit_data_o, flit_port_o, credit_o, credit_vc_o, err_o
  );

  modport master (
    output flit_valid_i, flit_vc_i, flit_head_i, flit_tail_i, flit_data_i, route_i,
    output grant_i, credit_valid_i, credit_vc_i,
    input  request_o, out_port_o, flit_valid_o, flit_vc_o, flit_head_o, flit_tail_o,
    input  flit_data_o, flit_port_o, credit_o, credit_vc_o, err_o
  );
endinterface

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - Per-input-port VC buffer feeding the VC allocator
// One FIFO per VC, per-VC downstream credit counters and packet-state tracking.
module input_vc_buffer #(
  parameter int vc_Num     = 4,
  parameter int BUF_DEPTH  = 4,
  parameter int FLIT_W     = 32,
  parameter int PORT_W     = 3,
  parameter int DN_CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input_vc_buffer_if.slave bus
);
  localparam int VC_W  = (vc_Num > 1) ? $clog2(vc_Num) : 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int CR_W  = $clog2(DN_CREDITS + 1);
  localparam int ENT_W = FLIT_W + PORT_W + 2;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [ENT_W-1:0]  mem_q      [vc_Num][BUF_DEPTH];
  logic [ENT_W-1:0]  mem_d      [vc_Num][BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q   [vc_Num];
  logic [PTR_W-1:0]  rd_ptr_d   [vc_Num];
  logic [PTR_W-1:0]  wr_ptr_q   [vc_Num];
  logic [PTR_W-1:0]  wr_ptr_d   [vc_Num];
  logic [CNT_W-1:0]  cnt_q      [vc_Num];
  logic [CNT_W-1:0]  cnt_d      [vc_Num];
  logic [CR_W-1:0]   cred_q     [vc_Num];
  logic [CR_W-1:0]   cred_d     [vc_Num];
  logic [0:0]        state_q    [vc_Num];
  logic [0:0]        state_d    [vc_Num];
  logic [PORT_W-1:0] in_route_q [vc_Num];
  logic [PORT_W-1:0] in_route_d [vc_Num];
  logic              err_q, err_d;
  logic              flit_valid_q, flit_valid_d, flit_head_q, flit_head_d;
  logic              flit_tail_q, flit_tail_d, credit_q, credit_d;
  logic [VC_W-1:0]   flit_vc_q, flit_vc_d, credit_vc_q, credit_vc_d;
  logic [FLIT_W-1:0] flit_data_q, flit_data_d;
  logic [PORT_W-1:0] flit_port_q, flit_port_d;

  logic [ENT_W-1:0]  front [vc_Num];
  logic [ENT_W-1:0]  pop_ent, wr_ent;
  logic [vc_Num-1:0] req, honoured, pop_vec, wr_vec, cr_vec;
  logic [VC_W-1:0]   pop_vc;
  logic              pop_en, wr_ok;

  always_comb begin
    for (int v = 0; v < vc_Num; v++) begin
      front[v] = mem_q[v][rd_ptr_q[v]];
      req[v]   = (cnt_q[v] != '0) && (cred_q[v] != '0);
      bus.out_port_o[v*PORT_W +: PORT_W] = (cnt_q[v] != '0) ? front[v][PORT_W-1:0] : '0;
    end
    honoured = bus.grant_i & req;
    pop_en   = |honoured;
    pop_vc   = '0;
    for (int v = vc_Num - 1; v >= 0; v--) begin
      if (honoured[v]) pop_vc = VC_W'(v);
    end
    pop_ent = front[pop_vc];
    pop_vec = pop_en ? (vc_Num'(1) << pop_vc) : '0;
    cr_vec  = bus.credit_valid_i ? (vc_Num'(1) << bus.credit_vc_i) : '0;
    // A full VC still takes a write when it is popped in the same cycle.
    wr_ok   = (cnt_q[bus.flit_vc_i] != CNT_W'(BUF_DEPTH)) || pop_vec[bus.flit_vc_i];
    wr_vec  = (bus.flit_valid_i && wr_ok) ? (vc_Num'(1) << bus.flit_vc_i) : '0;
    wr_ent  = {bus.flit_head_i, bus.flit_tail_i, bus.flit_data_i,
               bus.flit_head_i ? bus.route_i : in_route_q[bus.flit_vc_i]};
  end

  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    cred_d       = cred_q;
    state_d      = state_q;
    in_route_d   = in_route_q;
    err_d        = err_q;
    flit_valid_d = 1'b0;
    flit_vc_d    = '0;
    flit_head_d  = 1'b0;
    flit_tail_d  = 1'b0;
    flit_data_d  = '0;
    flit_port_d  = '0;
    credit_d     = 1'b0;
    credit_vc_d  = '0;

    if (((bus.grant_i & ~req) != '0) || ($countones(bus.grant_i) > 1)) err_d = 1'b1;

    if (pop_en) begin
      rd_ptr_d[pop_vc] = rd_ptr_q[pop_vc] + PTR_W'(1);
      flit_valid_d = 1'b1;
      flit_vc_d    = pop_vc;
      flit_head_d  = pop_ent[ENT_W-1];
      flit_tail_d  = pop_ent[ENT_W-2];
      flit_data_d  = pop_ent[ENT_W-3 -: FLIT_W];
      flit_port_d  = pop_ent[PORT_W-1:0];
      credit_d     = 1'b1;
      credit_vc_d  = pop_vc;
      if (pop_ent[ENT_W-1] && (state_q[pop_vc] == ST_ACTIVE)) err_d = 1'b1;
      if (!pop_ent[ENT_W-1] && (state_q[pop_vc] == ST_IDLE)) err_d = 1'b1;
      if (pop_ent[ENT_W-2])      state_d[pop_vc] = ST_IDLE;
      else if (pop_ent[ENT_W-1]) state_d[pop_vc] = ST_ACTIVE;
    end

    if (bus.flit_valid_i) begin
      if (wr_ok) begin
        mem_d[bus.flit_vc_i][wr_ptr_q[bus.flit_vc_i]] = wr_ent;
        wr_ptr_d[bus.flit_vc_i] = wr_ptr_q[bus.flit_vc_i] + PTR_W'(1);
        if (bus.flit_head_i) in_route_d[bus.flit_vc_i] = bus.route_i;
      end else begin
        err_d = 1'b1;
      end
    end

    for (int v = 0; v < vc_Num; v++) begin
      cnt_d[v] = cnt_q[v] + CNT_W'(wr_vec[v]) - CNT_W'(pop_vec[v]);
      if (pop_vec[v] && !cr_vec[v]) begin
        cred_d[v] = cred_q[v] - CR_W'(1);
      end else if (cr_vec[v] && !pop_vec[v]) begin
        if (cred_q[v] == CR_W'(DN_CREDITS)) err_d = 1'b1;
        else cred_d[v] = cred_q[v] + CR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < vc_Num; v++) begin
        for (int e = 0; e < BUF_DEPTH; e++) mem_q[v][e] <= '0;
        rd_ptr_q[v]   <= '0;
        wr_ptr_q[v]   <= '0;
        cnt_q[v]      <= '0;
        cred_q[v]     <= CR_W'(DN_CREDITS);
        state_q[v]    <= ST_IDLE;
        in_route_q[v] <= '0;
      end
      err_q        <= 1'b0;
      flit_valid_q <= 1'b0;
      flit_vc_q    <= '0;
      flit_head_q  <= 1'b0;
      flit_tail_q  <= 1'b0;
      flit_data_q  <= '0;
      flit_port_q  <= '0;
      credit_q     <= 1'b0;
      credit_vc_q  <= '0;
    end else begin
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      cred_q       <= cred_d;
      state_q      <= state_d;
      in_route_q   <= in_route_d;
      err_q        <= err_d;
      flit_valid_q <= flit_valid_d;
      flit_vc_q    <= flit_vc_d;
      flit_head_q  <= flit_head_d;
      flit_tail_q  <= flit_tail_d;
      flit_data_q  <= flit_data_d;
      flit_port_q  <= flit_port_d;
      credit_q     <= credit_d;
      credit_vc_q  <= credit_vc_d;
    end
  end

  assign bus.request_o    = req;
  assign bus.flit_valid_o = flit_valid_q;
  assign bus.flit_vc_o    = flit_vc_q;
  assign bus.flit_head_o  = flit_head_q;
  assign bus.flit_tail_o  = flit_tail_q;
  assign bus.flit_data_o  = flit_data_q;
  assign bus.flit_port_o  = flit_port_q;
  assign bus.credit_o     = credit_q;
  assign bus.credit_vc_o  = credit_vc_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - Bench for input_vc_buffer
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_input_vc_buffer;
  localparam int NV = 4;
  localparam int DEPTH = 4;
  localparam int DNC = 4;

  typedef struct packed {
    logic       h;
    logic       t;
    logic [31:0] d;
    logic [2:0] r;
  } flit_t;

  logic clk;
  logic rst_n;
  input_vc_buffer_if #(.vc_Num(NV), .FLIT_W(32), .PORT_W(3)) bus ();

  input_vc_buffer #(
    .vc_Num(NV), .BUF_DEPTH(DEPTH), .FLIT_W(32), .PORT_W(3), .DN_CREDITS(DNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  flit_t       mq [NV][$];
  int          mcred [NV];
  bit          mact [NV];
  logic [2:0]  minr [NV];
  bit          merr;
  logic        e_fv, e_h, e_t, e_cr;
  logic [1:0]  e_vc, e_crvc;
  logic [31:0] e_d;
  logic [2:0]  e_port;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.flit_valid_i   = 1'b0;
    bus.flit_vc_i      = '0;
    bus.flit_head_i    = 1'b0;
    bus.flit_tail_i    = 1'b0;
    bus.flit_data_i    = '0;
    bus.route_i        = '0;
    bus.grant_i        = '0;
    bus.credit_valid_i = 1'b0;
    bus.credit_vc_i    = '0;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mcred[v] = DNC;
      mact[v]  = 1'b0;
      minr[v]  = '0;
    end
    merr = 1'b0;
    {e_fv, e_h, e_t, e_cr, e_vc, e_crvc, e_d, e_port} = '0;
  endtask

  function automatic logic [3:0] model_req();
    logic [3:0] r;
    for (int v = 0; v < NV; v++) r[v] = (mq[v].size() > 0) && (mcred[v] > 0);
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] req;
    int         p;
    int         wv;
    flit_t      f;
    req = model_req();
    if (((bus.grant_i & ~req) != 0) || ($countones(bus.grant_i) > 1)) merr = 1'b1;
    p = -1;
    for (int v = NV - 1; v >= 0; v--) if (bus.grant_i[v] && req[v]) p = v;
    {e_fv, e_h, e_t, e_cr, e_vc, e_crvc, e_d, e_port} = '0;
    if (p >= 0) begin
      f = mq[p].pop_front();
      e_fv = 1'b1; e_cr = 1'b1; e_vc = 2'(p); e_crvc = 2'(p);
      e_h = f.h; e_t = f.t; e_d = f.d; e_port = f.r;
      if (f.h && mact[p]) merr = 1'b1;
      if (!f.h && !mact[p]) merr = 1'b1;
      if (f.t) mact[p] = 1'b0;
      else if (f.h) mact[p] = 1'b1;
      mcred[p]--;
    end
    if (bus.flit_valid_i) begin
      wv = int'(bus.flit_vc_i);
      if (mq[wv].size() < DEPTH) begin
        f.h = bus.flit_head_i; f.t = bus.flit_tail_i; f.d = bus.flit_data_i;
        f.r = bus.flit_head_i ? bus.route_i : minr[wv];
        if (bus.flit_head_i) minr[wv] = bus.route_i;
        mq[wv].push_back(f);
      end else begin
        merr = 1'b1;
      end
    end
    if (bus.credit_valid_i) begin
      if (mcred[bus.credit_vc_i] == DNC) merr = 1'b1;
      else mcred[bus.credit_vc_i]++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [11:0] ep;
    for (int v = 0; v < NV; v++) ep[v*3 +: 3] = (mq[v].size() > 0) ? mq[v][0].r : 3'd0;
    check_eq({tag, ".req"},   bus.request_o,    model_req());
    check_eq({tag, ".oport"}, bus.out_port_o,   ep);
    check_eq({tag, ".fv"},    bus.flit_valid_o, e_fv);
    check_eq({tag, ".fvc"},   bus.flit_vc_o,    e_vc);
    check_eq({tag, ".head"},  bus.flit_head_o,  e_h);
    check_eq({tag, ".tail"},  bus.flit_tail_o,  e_t);
    check_eq({tag, ".data"},  bus.flit_data_o,  e_d);
    check_eq({tag, ".fport"}, bus.flit_port_o,  e_port);
    check_eq({tag, ".cr"},    bus.credit_o,     e_cr);
    check_eq({tag, ".crvc"},  bus.credit_vc_o,  e_crvc);
    check_eq({tag, ".err"},   bus.err_o,        merr);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
    idle_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("rst");
    rst_n = 1'b1;
  endtask

  task automatic drive_flit(input int vc, input bit h, input bit t, input logic [31:0] d, input logic [2:0] r);
    bus.flit_valid_i = 1'b1;
    bus.flit_vc_i    = 2'(vc);
    bus.flit_head_i  = h;
    bus.flit_tail_i  = t;
    bus.flit_data_i  = d;
    bus.route_i      = r;
  endtask

  initial begin
    logic [3:0] req;
    int         pick;
    rst_n = 1'b1;
    idle_inputs();
    #2;

    // 1: two-flit packet on VC1 routed to port 2
    do_reset();
    check_eq("t1_err0", bus.err_o, 1'b0);
    drive_flit(1, 1, 0, 32'hA1, 3'd2); step("t1w0");
    check_eq("t1_req", bus.request_o, 4'b0010);
    check_eq("t1_port1", bus.out_port_o[5:3], 3'd2);
    drive_flit(1, 0, 1, 32'hA2, 3'd5); step("t1w1");
    bus.grant_i = 4'b0010; step("t1g0");
    check_eq("t1_fv0", bus.flit_valid_o, 1'b1);
    check_eq("t1_fp0", bus.flit_port_o, 3'd2);
    check_eq("t1_crvc0", bus.credit_vc_o, 2'd1);
    bus.grant_i = 4'b0010; step("t1g1");
    check_eq("t1_fv1", bus.flit_valid_o, 1'b1);
    check_eq("t1_fp1", bus.flit_port_o, 3'd2);
    check_eq("t1_tail1", bus.flit_tail_o, 1'b1);
    step("t1idle");
    check_eq("t1_fvoff", bus.flit_valid_o, 1'b0);

    // 2: overflow of VC0
    do_reset();
    for (int i = 0; i < 4; i++) begin drive_flit(0, 1, 1, 32'(i), 3'(i)); step("t2w"); end
    check_eq("t2_err_pre", bus.err_o, 1'b0);
    drive_flit(0, 1, 1, 32'd99, 3'd1); step("t2ovf");
    check_eq("t2_err", bus.err_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.grant_i = 4'b0001; step("t2pop");
      check_eq("t2_data", bus.flit_data_o, 32'(i));
    end
    bus.credit_valid_i = 1'b1; bus.credit_vc_i = 2'd0; step("t2cr");
    check_eq("t2_empty", bus.request_o[0], 1'b0);

    // 3 and 4: credit exhaustion on VC3, write-at-full with pop on VC2
    do_reset();
    for (int i = 0; i < 4; i++) begin drive_flit(3, 1, 1, 32'h300 + 32'(i), 3'd4); step("t3w"); end
    for (int i = 0; i < 4; i++) begin
      drive_flit(3, 1, 1, 32'h310 + 32'(i), 3'd4); bus.grant_i = 4'b1000; step("t3pw");
      check_eq("t3_fv", bus.flit_valid_o, 1'b1);
    end
    check_eq("t3_nocred", bus.request_o[3], 1'b0);
    check_eq("t3_err", bus.err_o, 1'b0);
    bus.credit_valid_i = 1'b1; bus.credit_vc_i = 2'd3; step("t3cr");
    check_eq("t3_req", bus.request_o[3], 1'b1);
    for (int i = 0; i < 4; i++) begin drive_flit(2, 1, 1, 32'h200 + 32'(i), 3'd6); step("t4w"); end
    drive_flit(2, 1, 1, 32'h2FF, 3'd6); bus.grant_i = 4'b0100; step("t4full");
    check_eq("t4_err", bus.err_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.grant_i = 4'b0100; bus.credit_valid_i = 1'b1; bus.credit_vc_i = 2'd2; step("t4pop");
      check_eq("t4_fv", bus.flit_valid_o, 1'b1);
    end
    check_eq("t4_drained", bus.request_o[2], 1'b0);
    check_eq("t4_last", bus.flit_data_o, 32'h2FF);

    // 5: multi-hot grant and grant to an empty VC
    do_reset();
    drive_flit(0, 1, 1, 32'h50, 3'd1); step("t5w0");
    drive_flit(2, 1, 1, 32'h52, 3'd3); step("t5w2");
    bus.grant_i = 4'b0101; step("t5mh");
    check_eq("t5_vc", bus.flit_vc_o, 2'd0);
    check_eq("t5_err", bus.err_o, 1'b1);
    do_reset();
    bus.grant_i = 4'b1000; step("t5empty");
    check_eq("t5_nopop", bus.flit_valid_o, 1'b0);
    check_eq("t5_err2", bus.err_o, 1'b1);

    // 6: asynchronous reset with a partly forwarded packet
    do_reset();
    drive_flit(1, 1, 0, 32'h61, 3'd7); step("t6w");
    for (int i = 0; i < 3; i++) begin drive_flit(1, 0, i == 2, 32'h62 + 32'(i), 3'd0); step("t6w"); end
    bus.grant_i = 4'b0010; step("t6pop");
    check_eq("t6_fv", bus.flit_valid_o, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) < 6)
          drive_flit(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, 3'($urandom));
        req = model_req();
        pick = int'($urandom_range(0, 9));
        if (pick < 7 && req != 0) begin
          int v;
          v = int'($urandom_range(0, 3));
          while (!req[v]) v = (v + 1) % NV;
          bus.grant_i = 4'(1 << v);
        end else if (pick == 7) begin
          bus.grant_i = 4'($urandom);
        end
        if ($urandom_range(0, 9) < 3) begin
          bus.credit_valid_i = 1'b1;
          bus.credit_vc_i    = 2'($urandom);
        end
        step("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
